// File: rtl/seven_seg_mux_ctrl.sv
// seven_seg_mux_ctrl
// Time-shares a single seven_seg_disp decoder between two common-anode
// digits. Each digit is driven for HOLD cycles, separated by BLANK dead
// cycles so the decoder value never changes while an anode is on. All
// outputs are registered.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   en         display enable (low = both digits dark, FSM parked in IDLE)
//   s0, s1     hex values for digit 0 (right) and digit 1 (left)
//   s_out      value presented to the shared decoder
//   an0, an1   active-low anode enables for digit 0 / digit 1
//   frame_done one-cycle pulse on the first cycle of each new frame
//
// state | meaning
// IDLE  | display dark, s_out holds last value
// DIG0  | digit 0 lit for HOLD cycles
// GAP0  | both dark for BLANK cycles
// DIG1  | digit 1 lit for HOLD cycles
// GAP1  | both dark for BLANK cycles
module seven_seg_mux_ctrl #(
  parameter int HOLD  = 2000,
  parameter int BLANK = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] s_out,
  output logic       an0,
  output logic       an1,
  output logic       frame_done
);

  localparam int MAXHB = (HOLD > BLANK) ? HOLD : BLANK;
  localparam int MAXC  = (MAXHB > 2) ? MAXHB : 2;
  localparam int CW    = $clog2(MAXC);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    DIG0,
    GAP0,
    DIG1,
    GAP1
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      s_out_nx;
  logic            an0_nx, an1_nx, fd_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (en) state_nx = DIG0;
      end
      DIG0: begin
        if (cnt == HOLD_LAST) begin
          if (BLANK == 0) state_nx = DIG1;
          else            state_nx = GAP0;
        end
      end
      GAP0: begin
        if (cnt == BLANK_LAST) state_nx = DIG1;
      end
      DIG1: begin
        if (cnt == HOLD_LAST) begin
          if (BLANK == 0) state_nx = DIG0;
          else            state_nx = GAP1;
        end
      end
      GAP1: begin
        if (cnt == BLANK_LAST) state_nx = DIG0;
      end
      default: state_nx = IDLE;
    endcase

    // Dropping enable always parks the FSM; re-enable restarts at DIG0.
    if (!en) state_nx = IDLE;
    if (state_nx != state) cnt_nx = '0;

    // Anodes are decoded from the single next state, so both can never be
    // low together, even on back-to-back DIG0/DIG1 with no gap.
    an0_nx = (state_nx != DIG0);
    an1_nx = (state_nx != DIG1);

    // Digit values are captured only on entry so mid-digit input changes
    // never glitch the lit segment.
    s_out_nx = s_out;
    if (state_nx == DIG0 && state != DIG0)      s_out_nx = s0;
    else if (state_nx == DIG1 && state != DIG1) s_out_nx = s1;

    // DIG1 -> DIG0 is only reachable when BLANK is zero.
    fd_nx = (state_nx == DIG0) && (state == GAP1 || state == DIG1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      s_out      <= 4'h0;
      an0        <= 1'b1;
      an1        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      s_out      <= s_out_nx;
      an0        <= an0_nx;
      an1        <= an1_nx;
      frame_done <= fd_nx;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
module tb_seven_seg_mux_ctrl;

  logic       clk = 1'b0;
  // dut: HOLD=4, BLANK=1
  logic       reset, en;
  logic [3:0] s0, s1, s_out;
  logic       an0, an1, frame_done;
  // dut_b: HOLD=2, BLANK=0
  logic       reset_b, en_b;
  logic [3:0] s0_b, s1_b, s_out_b;
  logic       an0_b, an1_b, frame_done_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_seg_mux_ctrl #(.HOLD(4), .BLANK(1)) dut (
    .clk(clk), .reset(reset), .en(en), .s0(s0), .s1(s1),
    .s_out(s_out), .an0(an0), .an1(an1), .frame_done(frame_done)
  );

  seven_seg_mux_ctrl #(.HOLD(2), .BLANK(0)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .s0(s0_b), .s1(s1_b),
    .s_out(s_out_b), .an0(an0_b), .an1(an1_b), .frame_done(frame_done_b)
  );

  // Advance one clock and check that neither instance ever lights both digits.
  task automatic tick();
    @(posedge clk);
    #1;
    n_cmp++;
    if (an0 === 1'b0 && an1 === 1'b0) begin
      n_err++;
      $display("FAIL overlap_a: an0=%b an1=%b required not both 0", an0, an1);
    end
    n_cmp++;
    if (an0_b === 1'b0 && an1_b === 1'b0) begin
      n_err++;
      $display("FAIL overlap_b: an0=%b an1=%b required not both 0", an0_b, an1_b);
    end
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b1; en = 1'b1; s0 = 4'h3; s1 = 4'hA;
    tick(); tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== 7'b110_0000) begin
      n_err++;
      $display("FAIL reset_state: got %b required %b", obs, 7'b110_0000);
    end
    reset = 1'b0; en = 1'b0;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== 7'b110_0000) begin
      n_err++;
      $display("FAIL idle_en_low: got %b required %b", obs, 7'b110_0000);
    end
  endtask

  task automatic test_frame();
    logic [6:0] obs, exp;
    int ph;
    en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      ph = i % 10;
      if (ph < 4)       exp = {1'b0, 1'b1, 1'b0, 4'h3};
      else if (ph == 4) exp = {1'b1, 1'b1, 1'b0, 4'h3};
      else if (ph < 9)  exp = {1'b1, 1'b0, 1'b0, 4'hA};
      else              exp = {1'b1, 1'b1, 1'b0, 4'hA};
      if (ph == 0 && i > 0) exp[4] = 1'b1;
      obs = {an0, an1, frame_done, s_out};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL frame cyc%0d: got %b required %b", i, obs, exp);
      end
    end
    en = 1'b0;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b0, 4'h3}) begin
      n_err++;
      $display("FAIL en_drop_dig0: got %b required %b", obs, {1'b1, 1'b1, 1'b0, 4'h3});
    end
  endtask

  task automatic test_input_hold();
    logic [6:0] obs;
    logic [6:0] exp_tab [10];
    exp_tab = '{{2'b01, 1'b0, 4'h3}, {2'b01, 1'b0, 4'h3}, {2'b11, 1'b0, 4'h3},
                {2'b10, 1'b0, 4'hA}, {2'b10, 1'b0, 4'hA}, {2'b10, 1'b0, 4'hA},
                {2'b10, 1'b0, 4'hA}, {2'b11, 1'b0, 4'hA}, {2'b01, 1'b1, 4'h7},
                {2'b01, 1'b0, 4'h7}};
    en = 1'b1;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== {2'b01, 1'b0, 4'h3}) begin
      n_err++;
      $display("FAIL restart_from_idle: got %b required %b", obs, {2'b01, 1'b0, 4'h3});
    end
    tick();
    s0 = 4'h7;
    for (int j = 0; j < 10; j++) begin
      tick();
      obs = {an0, an1, frame_done, s_out};
      n_cmp++;
      if (obs !== exp_tab[j]) begin
        n_err++;
        $display("FAIL input_hold step%0d: got %b required %b", j, obs, exp_tab[j]);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [6:0] obs;
    repeat (5) tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== {2'b10, 1'b0, 4'hA}) begin
      n_err++;
      $display("FAIL dig1_c1: got %b required %b", obs, {2'b10, 1'b0, 4'hA});
    end
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      obs = {an0, an1, frame_done, s_out};
      n_cmp++;
      if (obs !== {2'b11, 1'b0, 4'hA}) begin
        n_err++;
        $display("FAIL en_drop_dig1 cyc%0d: got %b required %b", k, obs, {2'b11, 1'b0, 4'hA});
      end
    end
    en = 1'b1;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== {2'b01, 1'b0, 4'h7}) begin
      n_err++;
      $display("FAIL reenable: got %b required %b", obs, {2'b01, 1'b0, 4'h7});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [6:0] obs;
    repeat (3) tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== {2'b11, 1'b0, 4'h7}) begin
      n_err++;
      $display("FAIL gap0: got %b required %b", obs, {2'b11, 1'b0, 4'h7});
    end
    reset = 1'b1;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== 7'b110_0000) begin
      n_err++;
      $display("FAIL reset_in_gap: got %b required %b", obs, 7'b110_0000);
    end
    reset = 1'b0;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== {2'b01, 1'b0, 4'h7}) begin
      n_err++;
      $display("FAIL release_gap: got %b required %b", obs, {2'b01, 1'b0, 4'h7});
    end
    tick();
    reset = 1'b1;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== 7'b110_0000) begin
      n_err++;
      $display("FAIL reset_in_digit: got %b required %b", obs, 7'b110_0000);
    end
    reset = 1'b0;
    tick();
    obs = {an0, an1, frame_done, s_out};
    n_cmp++;
    if (obs !== {2'b01, 1'b0, 4'h7}) begin
      n_err++;
      $display("FAIL release_digit: got %b required %b", obs, {2'b01, 1'b0, 4'h7});
    end
  endtask

  task automatic test_blank0();
    logic [6:0] obs, exp;
    int ph;
    reset_b = 1'b1; en_b = 1'b1; s0_b = 4'h5; s1_b = 4'hC;
    tick();
    obs = {an0_b, an1_b, frame_done_b, s_out_b};
    n_cmp++;
    if (obs !== 7'b110_0000) begin
      n_err++;
      $display("FAIL b_reset: got %b required %b", obs, 7'b110_0000);
    end
    reset_b = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      ph = i % 4;
      if (ph < 2) exp = {2'b01, 1'b0, 4'h5};
      else        exp = {2'b10, 1'b0, 4'hC};
      if (ph == 0 && i > 0) exp[4] = 1'b1;
      obs = {an0_b, an1_b, frame_done_b, s_out_b};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL blank0 cyc%0d: got %b required %b", i, obs, exp);
      end
    end
    en_b = 1'b0;
    tick();
    obs = {an0_b, an1_b, frame_done_b, s_out_b};
    n_cmp++;
    if (obs !== {2'b11, 1'b0, 4'h5}) begin
      n_err++;
      $display("FAIL b_en_drop: got %b required %b", obs, {2'b11, 1'b0, 4'h5});
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; s0 = 4'h0; s1 = 4'h0;
    reset_b = 1'b1; en_b = 1'b0; s0_b = 4'h0; s1_b = 4'h0;
    test_reset();
    test_frame();
    test_input_hold();
    test_en_drop();
    test_reset_mid();
    test_blank0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux_ctrl.md
SEVEN_SEG_MUX_CTRL -- requirements
Module: seven_seg_mux_ctrl

Interface
REQ-001 Parameter: HOLD, default 2000, cycles each digit is driven (HOLD >= 1).
REQ-002 Parameter: BLANK, default 20, dead cycles between digits (BLANK >= 0).
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  display enable; low = both digits dark.
REQ-006 Port: s0  input  4  hex value for digit 0 (right).
REQ-007 Port: s1  input  4  hex value for digit 1 (left).
REQ-008 Port: s_out  output  4  value presented to the shared seven_seg_disp decoder.
REQ-009 Port: an0  output  1  digit-0 common-anode enable, active-low.
REQ-010 Port: an1  output  1  digit-1 common-anode enable, active-low.
REQ-011 Port: frame_done  output  1  one-cycle pulse at each completed two-digit frame.

Function
REQ-012 The block SHALL time-share one seven_seg_disp decoder between two digits; all outputs registered.
REQ-013 FSM states SHALL be IDLE, DIG0, GAP0, DIG1, GAP1; a counter cnt (width clog2(max(HOLD,BLANK,2))) times each state.
REQ-014 IDLE: an0=an1=1, s_out holds last value; en=1 -> DIG0 at next edge with cnt=0.
REQ-015 DIG0: an0=0, an1=1 for exactly HOLD cycles, then GAP0 (or DIG1 directly if BLANK=0).
REQ-016 GAP0: an0=an1=1 for exactly BLANK cycles, then DIG1.
REQ-017 DIG1: an1=0, an0=1 for exactly HOLD cycles, then GAP1 (or DIG0 if BLANK=0).
REQ-018 GAP1: an0=an1=1 for exactly BLANK cycles, then DIG0.
REQ-019 an0 and an1 SHALL never be low in the same cycle, including across transitions and BLANK=0.
REQ-020 s_out SHALL load s0 on the same edge that enters DIG0 and s1 on the edge entering DIG1; otherwise s_out holds (input changes mid-digit not visible until next entry).
REQ-021 Frame period SHALL be 2*(HOLD+BLANK) cycles with en held high.
REQ-022 frame_done SHALL be high for exactly the first cycle of each DIG0 entered from GAP1 (or DIG1 if BLANK=0); never on DIG0 entered from IDLE.
REQ-023 en=0 in any non-IDLE state SHALL force IDLE at next edge: an0=an1=1 within one cycle, cnt cleared, frame_done=0.
REQ-024 en re-asserted SHALL always restart at DIG0 (no resume of prior position).
REQ-025 cnt SHALL reset to 0 on every state change; no wrap beyond HOLD-1/BLANK-1.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, cnt=0, s_out=4'h0, an0=an1=1, frame_done=0, overriding en and any state.
REQ-027 First edge with reset=0 and en=1 SHALL enter DIG0 (an0=0, s_out=s0).
REQ-028 Reset asserted mid-digit SHALL blank both anodes at that edge; no partial frame_done.

Verification (HOLD=4, BLANK=1 unless noted)
REQ-029 reset 2 cycles, en=1, s0=4'h3, s1=4'hA -> an0=0/s_out=3 for 4 cycles, both high 1 cycle, an1=0/s_out=A 4 cycles, both high 1 cycle, then DIG0 with frame_done=1 for 1 cycle; period 10.
REQ-030 In DIG0, change s0 3->7 at cycle 2 -> s_out stays 3 through DIG0; next frame DIG0 shows 7.
REQ-031 en=0 at cycle 2 of DIG1 -> next edge an0=an1=1, frame_done=0; en=1 again -> DIG0 next edge, no frame_done on that entry.
REQ-032 reset=1 during GAP0 -> next edge IDLE, s_out=0, anodes high; release with en=1 -> DIG0 next edge.
REQ-033 BLANK=0, HOLD=2 -> an0 low 2, an1 low 2, alternating with no gap, never both low; frame_done every 4 cycles.
REQ-034 Self-check every cycle: assert !(an0==0 && an1==0) and s_out equals latched digit value; bench reports error count and stops.
